// File: rtl/csr_exec_unit_if.sv
// Bus bundle between the CSR issue queue, the CSR file, the redirect source
// and the writeback arbiter on one side and csr_exec_unit on the other.
interface csr_exec_unit_if #(
  parameter int XLEN       = 64,
  parameter int PREG_WIDTH = 7,
  parameter int ROB_WIDTH  = 7
);
  logic                  issue_en;
  logic                  issue_ready;
  logic [2:0]            issue_op;
  logic [11:0]           issue_csr_addr;
  logic [XLEN-1:0]       issue_rs1_data;
  logic [4:0]            issue_imm;
  logic                  issue_rs1_zero;
  logic [PREG_WIDTH-1:0] issue_rd;
  logic [ROB_WIDTH-1:0]  issue_rob_idx;

  logic [11:0]           csr_raddr;
  logic [XLEN-1:0]       csr_rdata;
  logic                  csr_exist;
  logic                  csr_we;
  logic [11:0]           csr_waddr;
  logic [XLEN-1:0]       csr_wdata;

  logic                  redirect;
  logic [ROB_WIDTH-1:0]  redirect_idx;

  logic                  wb_valid;
  logic                  wb_ready;
  logic [PREG_WIDTH-1:0] wb_rd;
  logic [XLEN-1:0]       wb_data;
  logic [ROB_WIDTH-1:0]  wb_rob_idx;
  logic                  wb_exc;

  modport master (
    output issue_en, issue_op, issue_csr_addr, issue_rs1_data, issue_imm,
           issue_rs1_zero, issue_rd, issue_rob_idx,
    input  issue_ready,
    input  csr_raddr, csr_we, csr_waddr, csr_wdata,
    output csr_rdata, csr_exist,
    output redirect, redirect_idx,
    input  wb_valid, wb_rd, wb_data, wb_rob_idx, wb_exc,
    output wb_ready
  );

  modport slave (
    input  issue_en, issue_op, issue_csr_addr, issue_rs1_data, issue_imm,
           issue_rs1_zero, issue_rd, issue_rob_idx,
    output issue_ready,
    output csr_raddr, csr_we, csr_waddr, csr_wdata,
    input  csr_rdata, csr_exist,
    input  redirect, redirect_idx,
    output wb_valid, wb_rd, wb_data, wb_rob_idx, wb_exc,
    input  wb_ready
  );
endinterface

// File: rtl/csr_exec_unit.sv
// Two-stage CSR execution unit: S1 reads the CSR file and commits the
// read-modify-write once; WB holds the old value for the writeback arbiter.
module csr_exec_unit #(
  parameter int XLEN       = 64,
  parameter int PREG_WIDTH = 7,
  parameter int ROB_WIDTH  = 7
) (
  input logic           clk,
  input logic           rst,
  csr_exec_unit_if.slave bus
);

  // MSB of a robIdx is the wrap bit; across a wrap the index order flips.
  function automatic logic older(input logic [ROB_WIDTH-1:0] a,
                                 input logic [ROB_WIDTH-1:0] b);
    if (a[ROB_WIDTH-1] == b[ROB_WIDTH-1])
      return a[ROB_WIDTH-2:0] < b[ROB_WIDTH-2:0];
    else
      return a[ROB_WIDTH-2:0] > b[ROB_WIDTH-2:0];
  endfunction

  logic                  s1_valid;
  logic [1:0]            s1_op;
  logic [11:0]           s1_addr;
  logic [XLEN-1:0]       s1_operand;
  logic                  s1_wintent;
  logic [PREG_WIDTH-1:0] s1_rd;
  logic [ROB_WIDTH-1:0]  s1_rob;

  logic                  wb_valid_q;
  logic [PREG_WIDTH-1:0] wb_rd_q;
  logic [XLEN-1:0]       wb_data_q;
  logic [ROB_WIDTH-1:0]  wb_rob_q;
  logic                  wb_exc_q;

  logic                  wb_adv;
  logic                  issue_ready;
  logic                  kill_in;
  logic                  kill_s1;
  logic                  kill_wb;
  logic                  issue_fire;
  logic                  s1_adv;
  logic                  s1_illegal;
  logic                  csr_we;
  logic [XLEN-1:0]       s1_new;
  logic [XLEN-1:0]       issue_operand;
  logic                  issue_wintent;

  assign wb_adv      = !wb_valid_q | bus.wb_ready;
  assign issue_ready = !s1_valid | wb_adv;

  assign kill_in = bus.redirect & !older(bus.issue_rob_idx, bus.redirect_idx);
  assign kill_s1 = bus.redirect & !older(s1_rob, bus.redirect_idx);
  assign kill_wb = bus.redirect & !older(wb_rob_q, bus.redirect_idx);

  assign issue_fire    = bus.issue_en & issue_ready & !kill_in;
  assign issue_operand = bus.issue_op[2] ? {{(XLEN-5){1'b0}}, bus.issue_imm}
                                         : bus.issue_rs1_data;
  assign issue_wintent = (bus.issue_op[1:0] == 2'b01) | !bus.issue_rs1_zero;

  // Reserved funct3, unimplemented CSR, or a write aimed at a read-only CSR.
  assign s1_illegal = (s1_op == 2'b00) | !bus.csr_exist |
                      (s1_wintent & (s1_addr[11:10] == 2'b11));

  assign s1_adv = s1_valid & wb_adv & !kill_s1;

  // Gating on the advance makes a stalled S1 write exactly once.
  assign csr_we = s1_adv & s1_wintent & !s1_illegal & !rst;

  always_comb begin
    s1_new = s1_operand;
    case (s1_op)
      2'b10:   s1_new = bus.csr_rdata | s1_operand;
      2'b11:   s1_new = bus.csr_rdata & ~s1_operand;
      default: s1_new = s1_operand;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid   <= 1'b0;
      s1_op      <= '0;
      s1_addr    <= '0;
      s1_operand <= '0;
      s1_wintent <= 1'b0;
      s1_rd      <= '0;
      s1_rob     <= '0;
    end else if (issue_fire) begin
      s1_valid   <= 1'b1;
      s1_op      <= bus.issue_op[1:0];
      s1_addr    <= bus.issue_csr_addr;
      s1_operand <= issue_operand;
      s1_wintent <= issue_wintent;
      s1_rd      <= bus.issue_rd;
      s1_rob     <= bus.issue_rob_idx;
    end else if (s1_adv | kill_s1) begin
      s1_valid <= 1'b0;
    end
  end

  // WB payload only changes when S1 hands over, so it is stable under stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      wb_rob_q   <= '0;
      wb_exc_q   <= 1'b0;
    end else if (s1_adv) begin
      wb_valid_q <= 1'b1;
      wb_rd_q    <= s1_rd;
      wb_data_q  <= s1_illegal ? '0 : bus.csr_rdata;
      wb_rob_q   <= s1_rob;
      wb_exc_q   <= s1_illegal;
    end else if (bus.wb_ready | kill_wb) begin
      wb_valid_q <= 1'b0;
    end
  end

  assign bus.issue_ready = issue_ready;
  assign bus.csr_raddr   = s1_addr;
  assign bus.csr_we      = csr_we;
  assign bus.csr_waddr   = csr_we ? s1_addr : '0;
  assign bus.csr_wdata   = csr_we ? s1_new : '0;
  assign bus.wb_valid    = wb_valid_q;
  assign bus.wb_rd       = wb_rd_q;
  assign bus.wb_data     = wb_data_q;
  assign bus.wb_rob_idx  = wb_rob_q;
  assign bus.wb_exc      = wb_exc_q;

endmodule

// File: tb/tb_csr_exec_unit.sv
// Directed bench for csr_exec_unit: a vector table for single instructions plus
// hand-written sequences for backpressure, redirect kill and mid-run reset.
module tb_csr_exec_unit;

  logic clk;
  logic rst;

  csr_exec_unit_if #(.XLEN(64), .PREG_WIDTH(7), .ROB_WIDTH(7)) bus ();

  csr_exec_unit #(.XLEN(64), .PREG_WIDTH(7), .ROB_WIDTH(7)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // CSR file stand-in: combinational read, write on the strobe.
  logic [63:0] csr_mem [0:4095];
  bit          csr_ex  [0:4095];
  logic        preset_en;
  logic [11:0] preset_addr;
  logic [63:0] preset_val;
  int          we_total;

  assign bus.csr_rdata = csr_mem[bus.csr_raddr];
  assign bus.csr_exist = csr_ex[bus.csr_raddr];

  always @(posedge clk) begin
    if (bus.csr_we) begin
      csr_mem[bus.csr_waddr] <= bus.csr_wdata;
      we_total = we_total + 1;
    end else if (preset_en) begin
      csr_mem[preset_addr] <= preset_val;
    end
  end

  typedef struct {
    logic [2:0]  op;
    logic [11:0] addr;
    logic [63:0] rs1;
    logic [4:0]  imm;
    logic        rs1_zero;
    logic        exist;
    logic [63:0] old;
    logic        exp_we;
    logic [63:0] exp_wdata;
    logic [63:0] exp_wb;
    logic        exp_exc;
  } vec_t;

  localparam int NVEC = 13;
  vec_t vec [NVEC];
  int   total;
  int   bad;

  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic setCsr(input logic [11:0] addr, input logic [63:0] val,
                        input bit exist);
    csr_ex[addr] = exist;
    preset_addr  = addr;
    preset_val   = val;
    preset_en    = 1'b1;
    tick();
    preset_en    = 1'b0;
  endtask

  task automatic applyStimulus(input logic [2:0] op, input logic [11:0] addr,
                               input logic [63:0] rs1, input logic [4:0] imm,
                               input logic z, input logic [6:0] rd,
                               input logic [6:0] rob);
    bus.issue_en       = 1'b1;
    bus.issue_op       = op;
    bus.issue_csr_addr = addr;
    bus.issue_rs1_data = rs1;
    bus.issue_imm      = imm;
    bus.issue_rs1_zero = z;
    bus.issue_rd       = rd;
    bus.issue_rob_idx  = rob;
  endtask

  // Issue at c0, optional redirect during c1, watch whether it survives.
  task automatic runRedirect(input logic [6:0] rob, input logic [6:0] ridx,
                             input logic survive, input string tag);
    int wcnt;
    setCsr(12'h300, 64'h1, 1'b1);
    bus.wb_ready = 1'b1;
    applyStimulus(3'b010, 12'h300, 64'h2, 5'd0, 1'b0, 7'd5, rob);
    tick();
    bus.issue_en     = 1'b0;
    bus.redirect     = 1'b1;
    bus.redirect_idx = ridx;
    wcnt = we_total;
    settle();
    checkOutput({tag, " csr_we"}, 64'(bus.csr_we), 64'(survive));
    tick();
    bus.redirect = 1'b0;
    settle();
    checkOutput({tag, " wb_valid"}, 64'(bus.wb_valid), 64'(survive));
    checkOutput({tag, " writes"}, 64'(we_total - wcnt), 64'(survive));
    tick();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int wcnt;
    total = 0;
    bad = 0;
    we_total = 0;
    preset_en = 1'b0;
    preset_addr = '0;
    preset_val = '0;
    for (int i = 0; i < 4096; i++) csr_ex[i] = 1'b0;

    //          op      addr     rs1     imm  z  ex old       we wdata    wb       exc
    vec[0]  = '{3'b010, 12'h300, 64'h3,  5'd0,  0, 1, 64'h8,    1, 64'hB,  64'h8,    0};
    vec[1]  = '{3'b111, 12'h305, 64'h0,  5'd0,  1, 1, 64'h1234, 0, 64'h0,  64'h1234, 0};
    vec[2]  = '{3'b001, 12'hC00, 64'h5,  5'd0,  0, 1, 64'h99,   0, 64'h0,  64'h0,    1};
    vec[3]  = '{3'b011, 12'h341, 64'hF,  5'd0,  0, 1, 64'hFF,   1, 64'hF0, 64'hFF,   0};
    vec[4]  = '{3'b101, 12'h340, 64'h0,  5'h1F, 0, 1, 64'hDEAD, 1, 64'h1F, 64'hDEAD, 0};
    vec[5]  = '{3'b110, 12'h300, 64'h0,  5'd4,  0, 1, 64'hB,    1, 64'hF,  64'hB,    0};
    vec[6]  = '{3'b000, 12'h300, 64'h1,  5'd0,  0, 1, 64'h5,    0, 64'h0,  64'h0,    1};
    vec[7]  = '{3'b010, 12'h7C0, 64'h1,  5'd0,  0, 0, 64'h5,    0, 64'h0,  64'h0,    1};
    vec[8]  = '{3'b010, 12'hC01, 64'h0,  5'd0,  1, 1, 64'h77,   0, 64'h0,  64'h77,   0};
    vec[9]  = '{3'b111, 12'h344, 64'h0,  5'd3,  0, 1, 64'hF,    1, 64'hC,  64'hF,    0};
    vec[10] = '{3'b100, 12'h344, 64'h0,  5'd1,  0, 1, 64'hC,    0, 64'h0,  64'h0,    1};
    vec[11] = '{3'b101, 12'hC02, 64'h0,  5'd0,  1, 1, 64'h42,   0, 64'h0,  64'h0,    1};
    vec[12] = '{3'b001, 12'h300, 64'h0,  5'd0,  1, 1, 64'hF,    1, 64'h0,  64'hF,    0};

    rst = 1'b1;
    bus.issue_en = 1'b0;
    bus.issue_op = '0;
    bus.issue_csr_addr = '0;
    bus.issue_rs1_data = '0;
    bus.issue_imm = '0;
    bus.issue_rs1_zero = 1'b0;
    bus.issue_rd = '0;
    bus.issue_rob_idx = '0;
    bus.redirect = 1'b0;
    bus.redirect_idx = '0;
    bus.wb_ready = 1'b1;

    tick();
    tick();
    checkOutput("reset wb_valid", 64'(bus.wb_valid), 64'd0);
    checkOutput("reset csr_we", 64'(bus.csr_we), 64'd0);
    checkOutput("reset issue_ready", 64'(bus.issue_ready), 64'd1);
    checkOutput("reset wb_data", bus.wb_data, 64'd0);
    checkOutput("reset csr_wdata", bus.csr_wdata, 64'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < NVEC; i++) begin
      setCsr(vec[i].addr, vec[i].old, vec[i].exist);
      applyStimulus(vec[i].op, vec[i].addr, vec[i].rs1, vec[i].imm,
                    vec[i].rs1_zero, 7'(i + 1), 7'(i));
      settle();
      checkOutput($sformatf("v%0d issue_ready", i), 64'(bus.issue_ready), 64'd1);
      tick();
      bus.issue_en = 1'b0;
      settle();
      checkOutput($sformatf("v%0d csr_we", i), 64'(bus.csr_we), 64'(vec[i].exp_we));
      checkOutput($sformatf("v%0d csr_wdata", i), bus.csr_wdata, vec[i].exp_wdata);
      checkOutput($sformatf("v%0d csr_waddr", i), 64'(bus.csr_waddr),
                  vec[i].exp_we ? 64'(vec[i].addr) : 64'd0);
      tick();
      settle();
      checkOutput($sformatf("v%0d wb_valid", i), 64'(bus.wb_valid), 64'd1);
      checkOutput($sformatf("v%0d wb_data", i), bus.wb_data, vec[i].exp_wb);
      checkOutput($sformatf("v%0d wb_exc", i), 64'(bus.wb_exc), 64'(vec[i].exp_exc));
      checkOutput($sformatf("v%0d wb_rd", i), 64'(bus.wb_rd), 64'(i + 1));
      checkOutput($sformatf("v%0d wb_rob", i), 64'(bus.wb_rob_idx), 64'(i));
      checkOutput($sformatf("v%0d csr_mem", i), csr_mem[vec[i].addr],
                  vec[i].exp_we ? vec[i].exp_wdata : vec[i].old);
      tick();
      checkOutput($sformatf("v%0d drained", i), 64'(bus.wb_valid), 64'd0);
    end

    // Backpressure: two back-to-back issues, WB stalled for three cycles.
    setCsr(12'h300, 64'h10, 1'b1);
    setCsr(12'h341, 64'hF0, 1'b1);
    bus.wb_ready = 1'b1;
    applyStimulus(3'b010, 12'h300, 64'h1, 5'd0, 1'b0, 7'd3, 7'd20);
    tick();
    applyStimulus(3'b001, 12'h341, 64'hAB, 5'd0, 1'b0, 7'd4, 7'd21);
    settle();
    checkOutput("bp first we", 64'(bus.csr_we), 64'd1);
    checkOutput("bp first wdata", bus.csr_wdata, 64'h11);
    tick();
    bus.issue_en = 1'b0;
    bus.wb_ready = 1'b0;
    wcnt = we_total;
    for (int c = 0; c < 3; c++) begin
      settle();
      checkOutput($sformatf("bp stall%0d wb_valid", c), 64'(bus.wb_valid), 64'd1);
      checkOutput($sformatf("bp stall%0d wb_data", c), bus.wb_data, 64'h10);
      checkOutput($sformatf("bp stall%0d wb_rd", c), 64'(bus.wb_rd), 64'd3);
      checkOutput($sformatf("bp stall%0d issue_ready", c), 64'(bus.issue_ready), 64'd0);
      checkOutput($sformatf("bp stall%0d csr_we", c), 64'(bus.csr_we), 64'd0);
      tick();
    end
    bus.wb_ready = 1'b1;
    settle();
    checkOutput("bp second we", 64'(bus.csr_we), 64'd1);
    checkOutput("bp second waddr", 64'(bus.csr_waddr), 64'h341);
    checkOutput("bp second wdata", bus.csr_wdata, 64'hAB);
    checkOutput("bp first still", bus.wb_data, 64'h10);
    tick();
    settle();
    checkOutput("bp second wb_valid", 64'(bus.wb_valid), 64'd1);
    checkOutput("bp second wb_data", bus.wb_data, 64'hF0);
    checkOutput("bp second wb_rob", 64'(bus.wb_rob_idx), 64'd21);
    checkOutput("bp second writes", 64'(we_total - wcnt), 64'd1);
    tick();
    checkOutput("bp drained", 64'(bus.wb_valid), 64'd0);
    checkOutput("bp no extra write", 64'(we_total - wcnt), 64'd1);

    // Redirect against S1: equal/younger killed, older survives, wrap both ways.
    runRedirect(7'd5, 7'd5, 1'b0, "kill equal");
    runRedirect(7'd4, 7'd5, 1'b1, "keep older");
    runRedirect(7'd6, 7'd5, 1'b0, "kill younger");
    runRedirect(7'h46, 7'h02, 1'b1, "wrap keep");
    runRedirect(7'h02, 7'h46, 1'b0, "wrap kill");

    // Redirect kills a stalled WB entry even with wb_ready low.
    setCsr(12'h300, 64'h3, 1'b1);
    applyStimulus(3'b010, 12'h300, 64'h0, 5'd0, 1'b1, 7'd9, 7'd8);
    tick();
    bus.issue_en = 1'b0;
    bus.wb_ready = 1'b0;
    tick();
    settle();
    checkOutput("wbkill before", 64'(bus.wb_valid), 64'd1);
    bus.redirect = 1'b1;
    bus.redirect_idx = 7'd8;
    tick();
    bus.redirect = 1'b0;
    bus.wb_ready = 1'b1;
    settle();
    checkOutput("wbkill after", 64'(bus.wb_valid), 64'd0);
    tick();

    // Issue coinciding with a redirect that covers it is not accepted.
    wcnt = we_total;
    applyStimulus(3'b001, 12'h300, 64'h7, 5'd0, 1'b0, 7'd9, 7'd9);
    bus.redirect = 1'b1;
    bus.redirect_idx = 7'd9;
    tick();
    bus.issue_en = 1'b0;
    bus.redirect = 1'b0;
    settle();
    checkOutput("inkill csr_we", 64'(bus.csr_we), 64'd0);
    tick();
    checkOutput("inkill wb_valid", 64'(bus.wb_valid), 64'd0);
    checkOutput("inkill writes", 64'(we_total - wcnt), 64'd0);

    // Reset while S1 holds a write: no write in the reset cycle.
    wcnt = we_total;
    applyStimulus(3'b001, 12'h300, 64'h55, 5'd0, 1'b0, 7'd1, 7'd1);
    tick();
    bus.issue_en = 1'b0;
    rst = 1'b1;
    settle();
    checkOutput("midrst csr_we", 64'(bus.csr_we), 64'd0);
    tick();
    rst = 1'b0;
    settle();
    checkOutput("midrst wb_valid", 64'(bus.wb_valid), 64'd0);
    checkOutput("midrst issue_ready", 64'(bus.issue_ready), 64'd1);
    checkOutput("midrst csr_we after", 64'(bus.csr_we), 64'd0);
    tick();
    checkOutput("midrst writes", 64'(we_total - wcnt), 64'd0);
    checkOutput("midrst csr_mem", csr_mem[12'h300], 64'h3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
